// File: rtl/alu_pipe_if.sv
// alu_pipe handshake bundle: operand side (in_*, op, a, b, c_in) and
// result side (out_*, result, flags). slave = ALU, master = producer/consumer.
interface alu_pipe_if #(
  parameter int WIDTH = 8,
  parameter int OPW   = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [OPW-1:0]   op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             c_out;
  logic             zero;
  logic             neg;
  logic             ovf;
  logic             err;

  modport slave (
    input  in_valid, op, a, b, c_in, out_ready,
    output in_ready, out_valid, result,
    output c_out, zero, neg, ovf, err
  );

  modport master (
    output in_valid, op, a, b, c_in, out_ready,
    input  in_ready, out_valid, result,
    input  c_out, zero, neg, ovf, err
  );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with valid/ready in/out and one result slot.
// Ports: clk, rst_n (async low), bus (alu_pipe_if.slave).
// ALU_MUL_EN adds op 8: unsigned shift-add multiply, WIDTH busy cycles.
module alu_pipe #(
  parameter int WIDTH = 8,
  parameter int OPW   = 4
) (
  input logic      clk,
  input logic      rst_n,
  alu_pipe_if.slave bus
);

  localparam logic [OPW-1:0] OP_ADD  = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(1);
  localparam logic [OPW-1:0] OP_RSUB = OPW'(2);
  localparam logic [OPW-1:0] OP_OR   = OPW'(3);
  localparam logic [OPW-1:0] OP_AND  = OPW'(4);
  localparam logic [OPW-1:0] OP_ANDN = OPW'(5);
  localparam logic [OPW-1:0] OP_XOR  = OPW'(6);
  localparam logic [OPW-1:0] OP_XNOR = OPW'(7);

`ifdef ALU_MUL_EN
  localparam logic [OPW-1:0] OP_MUL  = OPW'(8);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {
    S_IDLE, S_HOLD, S_BUSY
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_HOLD
  } state_t;
`endif

  state_t state;

  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic             c_out;
  logic             zero;
  logic             neg;
  logic             ovf;
  logic             err;

  logic in_ready;
  logic acc;
  logic acc_alu;

  assign in_ready = (state == S_IDLE) ||
                    ((state == S_HOLD) && bus.out_ready);
  assign acc = bus.in_valid && in_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.result    = result;
  assign bus.c_out     = c_out;
  assign bus.zero      = zero;
  assign bus.neg       = neg;
  assign bus.ovf       = ovf;
  assign bus.err       = err;

  logic is_add, is_sub, is_rsub, is_or;
  logic is_and, is_andn, is_xor, is_xnor;

  assign is_add  = bus.op == OP_ADD;
  assign is_sub  = bus.op == OP_SUB;
  assign is_rsub = bus.op == OP_RSUB;
  assign is_or   = bus.op == OP_OR;
  assign is_and  = bus.op == OP_AND;
  assign is_andn = bus.op == OP_ANDN;
  assign is_xor  = bus.op == OP_XOR;
  assign is_xnor = bus.op == OP_XNOR;

`ifdef ALU_MUL_EN
  logic is_mul;
  logic acc_mul;
  assign is_mul  = bus.op == OP_MUL;
  assign acc_mul = acc && is_mul;
  assign acc_alu = acc && !is_mul;
`else
  assign acc_alu = acc;
`endif

  // SUB/RSUB are folded into one adder by selecting the
  // effective addends; overflow is judged on those addends.
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             ci;
  logic             arith;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] n_res;
  logic             n_c;
  logic             n_ovf;
  logic             n_err;

  always_comb begin
    x     = bus.a;
    y     = bus.b;
    ci    = bus.c_in;
    arith = 1'b0;
    n_res = '0;
    n_err = 1'b0;
    unique case (1'b1)
      is_add:  arith = 1'b1;
      is_sub: begin
        y     = ~bus.b;
        arith = 1'b1;
      end
      is_rsub: begin
        x     = bus.b;
        y     = ~bus.a;
        ci    = ~bus.c_in;
        arith = 1'b1;
      end
      is_or:   n_res = bus.a | bus.b;
      is_and:  n_res = bus.a & bus.b;
      is_andn: n_res = ~bus.a & bus.b;
      is_xor:  n_res = bus.a ^ bus.b;
      is_xnor: n_res = bus.a ~^ bus.b;
      default: n_err = 1'b1;
    endcase
    sum = {1'b0, x} + {1'b0, y} +
          {{WIDTH{1'b0}}, ci};
    n_c = 1'b0;
    if (arith) begin
      n_res = sum[WIDTH-1:0];
      n_c   = sum[WIDTH];
    end
    n_ovf = arith &&
            (x[WIDTH-1] == y[WIDTH-1]) &&
            (n_res[WIDTH-1] != x[WIDTH-1]);
  end

`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] mp;
  logic [2*WIDTH-1:0] ma;
  logic [WIDTH-1:0]   mb;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] mp_nxt;
  logic               m_last;

  assign mp_nxt = mb[0] ? mp + ma : mp;
  assign m_last = cnt == CW'(WIDTH - 1);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      c_out     <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      ovf       <= 1'b0;
      err       <= 1'b0;
`ifdef ALU_MUL_EN
      mp        <= '0;
      ma        <= '0;
      mb        <= '0;
      cnt       <= '0;
`endif
    end else if (acc_alu) begin
      state     <= S_HOLD;
      out_valid <= 1'b1;
      result    <= n_res;
      c_out     <= n_c;
      zero      <= n_res == '0;
      neg       <= n_res[WIDTH-1];
      ovf       <= n_ovf;
      err       <= n_err;
`ifdef ALU_MUL_EN
    end else if (acc_mul) begin
      state     <= S_BUSY;
      out_valid <= 1'b0;
      mp        <= '0;
      ma        <= {{WIDTH{1'b0}}, bus.a};
      mb        <= bus.b;
      cnt       <= '0;
    end else if (state == S_BUSY) begin
      mp  <= mp_nxt;
      ma  <= ma << 1;
      mb  <= mb >> 1;
      cnt <= cnt + 1'b1;
      if (m_last) begin
        state     <= S_HOLD;
        out_valid <= 1'b1;
        result    <= mp_nxt[WIDTH-1:0];
        c_out     <= |mp_nxt[2*WIDTH-1:WIDTH];
        zero      <= mp_nxt[WIDTH-1:0] == '0;
        neg       <= mp_nxt[WIDTH-1];
        ovf       <= 1'b0;
        err       <= 1'b0;
      end
`endif
    end else if (state == S_HOLD &&
                 bus.out_ready) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
    end
  end

endmodule
